omux_arbiter: RTL and testbench

Round-robin arbiter that shares the single FT2232 transmit path among N byte-stream requesters, such as the register manager's reply stream and the timetag event stream. Each requester raises `req`, presents a byte, and advances on a one-cycle `sel` pulse. The arbiter grants whole packets: the grant is held until the owner drops `req`. It forwards accepted bytes to the FT2232 writer as a registered data/strobe pair.

---
 rtl/omux_arbiter.sv | 171 +++++++++++++++++
 tb/tb_omux_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omux_arbiter.sv
// Round-robin packet arbiter sharing one FT2232 transmit byte path among N_REQ requesters.
// Optional per-grant burst limit enabled by defining OMUX_BURST_LIMIT_EN.
module omux_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]   sel_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [7:0]         out_data_o,
  output logic               out_wr_o,
  input  logic               out_rdy_i,
  output logic               busy_o
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("omux_arbiter: N_REQ must be in 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("omux_arbiter: MAX_BURST must be in 1..255");
  end

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] sel_c;
  logic [7:0]       out_data_q;
  logic             out_wr_q;
  logic             busy_q;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  int unsigned      rr_sum;
  logic [7:0]       owner_byte;
  logic             owner_req;
  logic             burst_release;

  // First pending request at or above ptr, wrapping at N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    rr_sum     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rr_sum = 32'(ptr_q) + i;
      if (rr_sum >= N_REQ) begin
        rr_sum = rr_sum - N_REQ;
      end
      cand = IDX_W'(rr_sum);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_byte = 8'h00;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        owner_byte = data_i[8*k +: 8];
      end
    end
  end

  assign owner_req = req_i[owner_q];

`ifdef OMUX_BURST_LIMIT_EN
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       others_pending;

  assign others_pending = |(req_i & ~grant_q);
  assign burst_release  = (burst_cnt_q == BURST_MAX) && others_pending;

  // Cleared on each new grant, saturates at the limit while nobody else waits.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == ST_IDLE && pick_found) begin
      burst_cnt_d = 8'h00;
    end else if ((|sel_c) && (burst_cnt_q != BURST_MAX)) begin
      burst_cnt_d = burst_cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      burst_cnt_q <= 8'h00;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign burst_release = 1'b0;
`endif

  // Next-state and accept logic; the grant only ends when the owner lets go.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d           = ST_GRANT;
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!owner_req || burst_release) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
        end else begin
          sel_c[owner_q] = out_rdy_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      out_data_q <= 8'h00;
      out_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      out_wr_q <= |sel_c;
      busy_q   <= (state_d == ST_GRANT);
      if (|sel_c) begin
        out_data_q <= owner_byte;
      end
    end
  end

  assign sel_o      = sel_c;
  assign grant_o    = grant_q;
  assign out_data_o = out_data_q;
  assign out_wr_o   = out_wr_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_omux_arbiter.sv
// Bench for omux_arbiter (N_REQ=3): queue-based requesters, a cycle model of the
// round-robin packet rules, and directed packet scenarios with hand-computed streams.
module tb_omux_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned MB = 4;

  logic           clk_i = 1'b0;
  logic           reset_n_i = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [8*N-1:0] data_i = '0;
  logic [N-1:0]   sel_o;
  logic [N-1:0]   grant_o;
  logic [7:0]     out_data_o;
  logic           out_wr_o;
  logic           out_rdy_i = 1'b1;
  logic           busy_o;

  always #5 clk_i = ~clk_i;

  omux_arbiter #(.N_REQ(N), .MAX_BURST(MB)) u_dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .sel_o      (sel_o),
    .grant_o    (grant_o),
    .out_data_o (out_data_o),
    .out_wr_o   (out_wr_o),
    .out_rdy_i  (out_rdy_i),
    .busy_o     (busy_o)
  );

  int tests_run = 0;
  int fails     = 0;

  // requester side
  logic [7:0] bytes_q [N][$];
  int         lens_q  [N][$];
  int         rem     [N];
  logic       rdy_q   [$];
  logic [N-1:0] sel_cap = '0;

  // observation
  logic [7:0] exp_stream [$];
  int         grant_log  [$];
  int         wr_cnt = 0;
  int         sel_cnt [N];
  int         last_gap = -1;
  int         gap_run = 0;
  bit         seen_wr = 0;
  logic [N-1:0] prev_grant = '0;

  // model
  int         m_owner = -1;
  int         m_ptr = 0;
  int         m_cnt = 0;
  logic       m_wr = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [N-1:0] exp_sel, exp_grant;
  bit         rel;
  logic [7:0] exp_b;

  initial begin
    for (int k = 0; k < N; k++) begin
      rem[k] = 0;
      sel_cnt[k] = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int k, input int len, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < len; i++) bytes_q[k].push_back(base + 8'(i) * step);
    lens_q[k].push_back(len);
  endtask

  task automatic push_exp(input int len, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < len; i++) exp_stream.push_back(base + 8'(i) * step);
  endtask

  task automatic wait_done(input string name);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < 300) begin
      @(negedge clk_i);
      n++;
      done = (req_i == '0) && (grant_o == '0);
      for (int k = 0; k < N; k++) if (lens_q[k].size() != 0 || rem[k] != 0) done = 0;
    end
    tests_run++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: still busy after %0d cycles", name, n);
    end
    repeat (2) @(negedge clk_i);
    check({name, "_stream_left"}, exp_stream.size(), 0);
  endtask

  task automatic check_glog(input string name, input int start, input int n,
                            input int e0, input int e1, input int e2, input int e3, input int e4);
    int e [5];
    e = '{e0, e1, e2, e3, e4};
    check({name, "_count"}, grant_log.size() - start, n);
    for (int i = 0; i < n; i++) begin
      if (start + i < grant_log.size()) check({name, "_order"}, grant_log[start+i], e[i]);
    end
  endtask

  // Requesters: hold req over a packet, advance on sel, drop req one cycle between packets.
  always @(posedge clk_i) begin
    #1;
    if (!reset_n_i) begin
      for (int k = 0; k < N; k++) begin
        bytes_q[k].delete();
        lens_q[k].delete();
        rem[k] = 0;
      end
      rdy_q.delete();
      out_rdy_i = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (sel_cap[k] && rem[k] > 0) begin
          bytes_q[k].delete(0);
          rem[k]--;
        end else if (rem[k] == 0 && lens_q[k].size() > 0) begin
          rem[k] = lens_q[k].pop_front();
        end
      end
      out_rdy_i = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      req_i[k] = (rem[k] > 0);
      data_i[8*k +: 8] = (rem[k] > 0) ? bytes_q[k][0] : 8'h00;
    end
  end

  // Model compare: every negedge, outputs against the arbitration rules.
  always @(negedge clk_i) begin
    if (!reset_n_i) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_wr = 1'b0; m_data = 8'h00;
      seen_wr = 0; gap_run = 0; prev_grant = '0;
    end
    exp_grant = '0;
    if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
`ifdef OMUX_BURST_LIMIT_EN
    rel = (m_owner >= 0) && (m_cnt == MB) && (|(req_i & ~exp_grant));
`else
    rel = 0;
`endif
    exp_sel = '0;
    if (m_owner >= 0 && !rel && req_i[m_owner] && out_rdy_i) exp_sel[m_owner] = 1'b1;
    check("grant", grant_o, exp_grant);
    check("busy", busy_o, m_owner >= 0);
    check("sel", sel_o, exp_sel);
    check("out_wr", out_wr_o, m_wr);
    check("out_data", out_data_o, m_data);
    if (!reset_n_i) begin
      sel_cap = '0;
    end else begin
      if (out_wr_o) begin
        wr_cnt++;
        if (seen_wr && gap_run > 0) last_gap = gap_run;
        gap_run = 0;
        seen_wr = 1;
        if (exp_stream.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL stream_extra: got %0h expected no byte", out_data_o);
        end else begin
          exp_b = exp_stream.pop_front();
          check("stream", out_data_o, exp_b);
        end
      end else if (seen_wr) begin
        gap_run++;
      end
      if (prev_grant == '0 && grant_o != '0)
        for (int k = 0; k < N; k++) if (grant_o[k]) grant_log.push_back(k);
      prev_grant = grant_o;
      for (int k = 0; k < N; k++) sel_cnt[k] += int'(sel_o[k]);
      sel_cap = sel_o;
      // model next state
      if (m_owner < 0) begin
        m_wr = 1'b0;
        for (int i = 0; i < N; i++)
          if (m_owner < 0 && req_i[(m_ptr + i) % N]) begin
            m_owner = (m_ptr + i) % N;
            m_cnt = 0;
          end
      end else if (!req_i[m_owner] || rel) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
        m_wr = 1'b0;
      end else begin
        m_wr = out_rdy_i;
        if (out_rdy_i) begin
          m_data = data_i[8*m_owner +: 8];
          if (m_cnt < MB) m_cnt++;
        end
      end
    end
  end

  initial begin
    int n, w0, s0, g0;
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0, s0, g0;
    repeat (2) @(posedge clk_i);
    #2 reset_n_i = 1'b1;
    @(negedge clk_i);
    check("rst_grant", grant_o, 0);
    check("rst_wr", out_wr_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_data", out_data_o, 0);

    // single requester, 5 bytes
    w0 = wr_cnt; s0 = sel_cnt[0];
    push_exp(5, 8'h11, 8'h11);
    push_pkt(0, 5, 8'h11, 8'h11);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!req_i[0] && n < 10);
    check("t2_grant_before", grant_o, 3'b000);
    @(negedge clk_i);
    check("t2_grant_after1", grant_o, 3'b001);
    check("t2_first_sel", sel_o, 3'b001);
    wait_done("t2");
    check("t2_writes", wr_cnt - w0, 5);
    check("t2_sels", sel_cnt[0] - s0, 5);
    check("t2_grant_end", grant_o, 0);

    // asynchronous reset in the middle of a packet from requester 1
    push_exp(6, 8'hA0, 8'h01);
    push_pkt(1, 6, 8'hA0, 8'h01);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!out_wr_o && n < 20);
    @(posedge clk_i);
    #2 check("rst_pre_grant", grant_o, 3'b010);
    #1 reset_n_i = 1'b0;
    #1;
    check("async_grant", grant_o, 0);
    check("async_wr", out_wr_o, 0);
    check("async_busy", busy_o, 0);
    check("async_sel", sel_o, 0);
    repeat (2) @(negedge clk_i);
    exp_stream.delete();
    @(posedge clk_i);
    #2 reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // simultaneous 0 and 1 with ptr=0: 0 first, two dead cycles, then 1
    g0 = grant_log.size();
    push_pkt(0, 3, 8'hC0, 8'h01);
    push_pkt(1, 3, 8'hD0, 8'h01);
    push_exp(3, 8'hC0, 8'h01);
    push_exp(3, 8'hD0, 8'h01);
    wait_done("t3a");
    check("t3a_gap", last_gap, 2);
    check_glog("t3a", g0, 2, 0, 1, 0, 0, 0);

    // ptr=2 now: requester 2 wins over 1
    g0 = grant_log.size();
    push_pkt(1, 2, 8'hD8, 8'h01);
    push_pkt(2, 2, 8'hE0, 8'h01);
    push_exp(2, 8'hE0, 8'h01);
    push_exp(2, 8'hD8, 8'h01);
    wait_done("t3b");
    check_glog("t3b", g0, 2, 2, 1, 0, 0, 0);

    // back-pressure: ready 1,1,0,0,1,0,1,1
    w0 = wr_cnt; s0 = sel_cnt[1]; g0 = grant_log.size();
    push_pkt(1, 4, 8'hF0, 8'h01);
    push_exp(4, 8'hF0, 8'h01);
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    wait_done("t4");
    check("t4_writes", wr_cnt - w0, 4);
    check("t4_sels", sel_cnt[1] - s0, 4);
    check_glog("t4", g0, 1, 1, 0, 0, 0, 0);

    // 0 and 2 re-requesting, 1 joins: from ptr=2 grants go 2,0,1,2,0
    g0 = grant_log.size();
    push_pkt(0, 2, 8'h01, 8'h01);
    push_pkt(0, 2, 8'h03, 8'h01);
    push_pkt(2, 2, 8'h21, 8'h01);
    push_pkt(2, 2, 8'h23, 8'h01);
    push_pkt(1, 2, 8'h11, 8'h01);
    push_exp(2, 8'h21, 8'h01);
    push_exp(2, 8'h01, 8'h01);
    push_exp(2, 8'h11, 8'h01);
    push_exp(2, 8'h23, 8'h01);
    push_exp(2, 8'h03, 8'h01);
    wait_done("t5");
    check_glog("t5", g0, 5, 2, 0, 1, 2, 0);

`ifdef OMUX_BURST_LIMIT_EN
    // bring ptr to 0, then 0 is split after 4 bytes while 1 waits
    push_pkt(2, 1, 8'h77, 8'h01);
    push_exp(1, 8'h77, 8'h01);
    wait_done("t6pre");
    g0 = grant_log.size();
    push_pkt(0, 10, 8'h40, 8'h01);
    push_pkt(1, 3, 8'h60, 8'h01);
    push_exp(4, 8'h40, 8'h01);
    push_exp(3, 8'h60, 8'h01);
    push_exp(6, 8'h44, 8'h01);
    wait_done("t6a");
    check_glog("t6a", g0, 3, 0, 1, 0, 0, 0);
    g0 = grant_log.size();
    push_pkt(0, 10, 8'h80, 8'h01);
    push_exp(10, 8'h80, 8'h01);
    wait_done("t6b");
    check_glog("t6b", g0, 1, 0, 0, 0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
